// File: rtl/fdtd_step_sched.sv
// fdtd_step_sched: time-step scheduler for the 1-D FDTD accelerator.
// Each step runs Hy update, Ez update and source injection. An optional field
// sample runs every smp_int steps. Each phase uses a start/done pulse handshake.
// Optional per-phase watchdog: define FDTD_SCHED_WDOG_EN to enable it.
module fdtd_step_sched #(
    parameter int STEP_W      = 16,
    parameter int SMP_W       = 8,
    parameter int WDOG_CYCLES = 65535
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              clr_i,
    input  logic              int_en_i,
    input  logic [STEP_W-1:0] num_steps_i,
    input  logic [SMP_W-1:0]  smp_int_i,
    output logic              hy_start_o,
    output logic              ez_start_o,
    output logic              src_start_o,
    output logic              smp_start_o,
    input  logic              hy_done_i,
    input  logic              ez_done_i,
    input  logic              src_done_i,
    input  logic              smp_done_i,
    output logic [2:0]        phase_o,
    output logic [STEP_W-1:0] step_cnt_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              aborted_o,
    output logic              irq_o,
    output logic              err_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_HY_REQ, S_HY_WAIT, S_EZ_REQ, S_EZ_WAIT, S_SRC_REQ, S_SRC_WAIT,
        S_SMP_REQ, S_SMP_WAIT, S_FIN, S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
    logic [STEP_W-1:0]   num_steps_q, num_steps_d;
    logic [SMP_W-1:0]    smp_int_q, smp_int_d;
    logic [SMP_W-1:0]    smp_cnt_q, smp_cnt_d;
    logic                irq_q, irq_d;
    logic                aborted_q, aborted_d;
    logic                busy_st;
    logic                wait_st;
    logic                wdog_expired;

    assign busy_st = (state_q != S_IDLE) && (state_q != S_ERR);
    assign wait_st = (state_q == S_HY_WAIT) || (state_q == S_EZ_WAIT) ||
                     (state_q == S_SRC_WAIT) || (state_q == S_SMP_WAIT);

`ifdef FDTD_SCHED_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic              err_q, err_d;

    assign wdog_expired = (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1));

    // Watchdog counter restarts on every entry into a wait state; sticky error flag.
    always_comb begin
        wdog_cnt_d = wait_st ? (wdog_cnt_q + WDOG_W'(1)) : '0;
        err_d      = err_q;
        if (clr_i) begin
            err_d = 1'b0;
        end
        if ((state_d == S_ERR) && (state_q != S_ERR)) begin
            err_d = 1'b1;
        end
    end

    // Watchdog state register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wdog_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            err_q      <= err_d;
        end
    end
`else
    // Timeout parameter has no effect when the watchdog is not built.
    logic unused_wdog;
    assign unused_wdog  = (WDOG_CYCLES != 0) && wait_st;
    assign wdog_expired = 1'b0;
`endif

    // Control state register; only control and the visible step count are reset.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= S_IDLE;
            step_cnt_q <= '0;
            irq_q      <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            irq_q      <= irq_d;
            aborted_q  <= aborted_d;
        end
    end

    // Run parameters and sample down-counter, always loaded before use.
    always_ff @(posedge ACLK) begin
        num_steps_q <= num_steps_d;
        smp_int_q   <= smp_int_d;
        smp_cnt_q   <= smp_cnt_d;
    end

    // Next-state and counter update logic.
    always_comb begin
        state_d     = state_q;
        step_cnt_d  = step_cnt_q;
        num_steps_d = num_steps_q;
        smp_int_d   = smp_int_q;
        smp_cnt_d   = smp_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    num_steps_d = num_steps_i;
                    smp_int_d   = smp_int_i;
                    smp_cnt_d   = smp_int_i;
                    step_cnt_d  = '0;
                    state_d     = (num_steps_i == '0) ? S_FIN : S_HY_REQ;
                end
            end
            S_HY_REQ:  state_d = S_HY_WAIT;
            S_HY_WAIT: begin
                if (hy_done_i)         state_d = S_EZ_REQ;
                else if (wdog_expired) state_d = S_ERR;
            end
            S_EZ_REQ:  state_d = S_EZ_WAIT;
            S_EZ_WAIT: begin
                if (ez_done_i)         state_d = S_SRC_REQ;
                else if (wdog_expired) state_d = S_ERR;
            end
            S_SRC_REQ: state_d = S_SRC_WAIT;
            S_SRC_WAIT: begin
                if (src_done_i) begin
                    step_cnt_d = step_cnt_q + STEP_W'(1);
                    if ((smp_int_q != '0) && (smp_cnt_q == SMP_W'(1))) begin
                        smp_cnt_d = smp_int_q;
                        state_d   = S_SMP_REQ;
                    end else begin
                        if (smp_int_q != '0) begin
                            smp_cnt_d = smp_cnt_q - SMP_W'(1);
                        end
                        state_d = (step_cnt_d == num_steps_q) ? S_FIN : S_HY_REQ;
                    end
                end else if (wdog_expired) begin
                    state_d = S_ERR;
                end
            end
            S_SMP_REQ: state_d = S_SMP_WAIT;
            S_SMP_WAIT: begin
                if (smp_done_i)        state_d = (step_cnt_q == num_steps_q) ? S_FIN : S_HY_REQ;
                else if (wdog_expired) state_d = S_ERR;
            end
            S_FIN:     state_d = S_IDLE;
            S_ERR:     if (clr_i) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        // Abort overrides any completion in the same cycle and freezes the step count.
        if (busy_st && abort_i) begin
            state_d    = S_IDLE;
            step_cnt_d = step_cnt_q;
            smp_cnt_d  = smp_cnt_q;
        end
    end

    // Sticky interrupt and one-cycle abort acknowledge; an irq set beats a clear.
    always_comb begin
        aborted_d = busy_st && abort_i;
        irq_d     = irq_q;
        if (clr_i) begin
            irq_d = 1'b0;
        end
        if ((state_q == S_FIN) && int_en_i && !abort_i) begin
            irq_d = 1'b1;
        end
    end

    // Moore output decode from the registered state.
    always_comb begin
        hy_start_o  = (state_q == S_HY_REQ);
        ez_start_o  = (state_q == S_EZ_REQ);
        src_start_o = (state_q == S_SRC_REQ);
        smp_start_o = (state_q == S_SMP_REQ);
        busy_o      = busy_st;
        done_o      = (state_q == S_FIN);
        aborted_o   = aborted_q;
        irq_o       = irq_q;
        step_cnt_o  = step_cnt_q;
`ifdef FDTD_SCHED_WDOG_EN
        err_o       = err_q;
`else
        err_o       = 1'b0;
`endif
        case (state_q)
            S_HY_REQ, S_HY_WAIT:   phase_o = 3'd1;
            S_EZ_REQ, S_EZ_WAIT:   phase_o = 3'd2;
            S_SRC_REQ, S_SRC_WAIT: phase_o = 3'd3;
            S_SMP_REQ, S_SMP_WAIT: phase_o = 3'd4;
            S_FIN:                 phase_o = 3'd5;  // wrap-up cycle, distinct from IDLE
            S_ERR:                 phase_o = 3'd7;
            default:               phase_o = 3'd0;
        endcase
    end

endmodule

// File: tb/tb_fdtd_step_sched.sv
// Testbench for fdtd_step_sched: table of complete runs plus directed corner sequences.
module tb_fdtd_step_sched;

    localparam int STEP_W = 16;
    localparam int SMP_W  = 8;
    localparam int WDOG   = 16;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic              start_i, abort_i, clr_i, int_en_i;
    logic [STEP_W-1:0] num_steps_i;
    logic [SMP_W-1:0]  smp_int_i;
    logic              hy_start_o, ez_start_o, src_start_o, smp_start_o;
    logic              hy_done_i, ez_done_i, src_done_i, smp_done_i;
    logic [2:0]        phase_o;
    logic [STEP_W-1:0] step_cnt_o;
    logic              busy_o, done_o, aborted_o, irq_o, err_o;

    // Automatic phase responder (done one cycle after start) plus manual overrides.
    logic auto_en;
    logic hy_prev, ez_prev, src_prev, smp_prev;
    logic hy_done_a, ez_done_a, src_done_a, smp_done_a;
    logic hy_done_m, ez_done_m, src_done_m, smp_done_m;

    assign hy_done_i  = hy_done_a  | hy_done_m;
    assign ez_done_i  = ez_done_a  | ez_done_m;
    assign src_done_i = src_done_a | src_done_m;
    assign smp_done_i = smp_done_a | smp_done_m;

    int n_checks = 0;
    int n_fail   = 0;

    fdtd_step_sched #(
        .STEP_W(STEP_W), .SMP_W(SMP_W), .WDOG_CYCLES(WDOG)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .start_i(start_i), .abort_i(abort_i), .clr_i(clr_i), .int_en_i(int_en_i),
        .num_steps_i(num_steps_i), .smp_int_i(smp_int_i),
        .hy_start_o(hy_start_o), .ez_start_o(ez_start_o),
        .src_start_o(src_start_o), .smp_start_o(smp_start_o),
        .hy_done_i(hy_done_i), .ez_done_i(ez_done_i),
        .src_done_i(src_done_i), .smp_done_i(smp_done_i),
        .phase_o(phase_o), .step_cnt_o(step_cnt_o), .busy_o(busy_o),
        .done_o(done_o), .aborted_o(aborted_o), .irq_o(irq_o), .err_o(err_o)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        hy_prev = 0; ez_prev = 0; src_prev = 0; smp_prev = 0;
        hy_done_a = 0; ez_done_a = 0; src_done_a = 0; smp_done_a = 0;
        forever begin
            @(negedge ACLK);
            hy_done_a  = auto_en & hy_prev;
            ez_done_a  = auto_en & ez_prev;
            src_done_a = auto_en & src_prev;
            smp_done_a = auto_en & smp_prev;
            hy_prev    = hy_start_o;
            ez_prev    = ez_start_o;
            src_prev   = src_start_o;
            smp_prev   = smp_start_o;
        end
    end

    // Start a run from IDLE at a falling edge; cycle 1 is the first cycle after start is sampled.
    task automatic run_seq(input int bound, output int done_cyc, output int hy_n, output int smp_n,
                           output int step_done, output int hy_first);
        done_cyc = -1; hy_n = 0; smp_n = 0; step_done = -1; hy_first = -1;
        start_i = 1'b1;
        @(negedge ACLK);
        start_i = 1'b0;
        for (int k = 1; k <= bound; k++) begin
            if (hy_start_o) begin
                hy_n++;
                if (hy_first < 0) hy_first = k;
            end
            if (smp_start_o) smp_n++;
            if (done_o) begin
                done_cyc  = k;
                step_done = int'(step_cnt_o);
                break;
            end
            @(negedge ACLK);
        end
    endtask

    typedef struct {
        int num;
        int smp;
        bit ien;
        int exp_hy;
        int exp_smp;
        int exp_done;
        bit exp_irq;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int dc, hn, sn, sd, hf, extra_hy;
        bit seen;

        vecs[0] = '{3, 0, 1'b1, 3, 0, 19, 1'b1};
        vecs[1] = '{4, 2, 1'b1, 4, 2, 29, 1'b1};
        vecs[2] = '{0, 0, 1'b1, 0, 0,  1, 1'b1};
        vecs[3] = '{1, 1, 1'b0, 1, 1,  9, 1'b0};
        vecs[4] = '{2, 3, 1'b1, 2, 0, 13, 1'b1};
        vecs[5] = '{5, 0, 1'b0, 5, 0, 31, 1'b0};

        ARESET = 1'b1; start_i = 0; abort_i = 0; clr_i = 0; int_en_i = 0;
        num_steps_i = '0; smp_int_i = '0; auto_en = 0;
        hy_done_m = 0; ez_done_m = 0; src_done_m = 0; smp_done_m = 0;
        repeat (3) @(negedge ACLK);

        check("reset_phase", phase_o, 0);
        check("reset_step", step_cnt_o, 0);
        check("reset_flags", {busy_o, done_o, aborted_o, irq_o, err_o}, 0);
        check("reset_starts", {hy_start_o, ez_start_o, src_start_o, smp_start_o}, 0);
        ARESET = 1'b0;
        @(negedge ACLK);

        // Table of complete runs with an automatic responder.
        auto_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            num_steps_i = STEP_W'(vecs[i].num);
            smp_int_i   = SMP_W'(vecs[i].smp);
            int_en_i    = vecs[i].ien;
            run_seq(200, dc, hn, sn, sd, hf);
            check($sformatf("v%0d_done_cycle", i), dc, vecs[i].exp_done);
            check($sformatf("v%0d_hy_pulses", i), hn, vecs[i].exp_hy);
            check($sformatf("v%0d_smp_pulses", i), sn, vecs[i].exp_smp);
            check($sformatf("v%0d_step_cnt", i), sd, vecs[i].num);
            check($sformatf("v%0d_hy_first", i), hf, (vecs[i].num == 0) ? -1 : 1);
            check($sformatf("v%0d_busy_in_fin", i), busy_o, 1);
            @(negedge ACLK);
            check($sformatf("v%0d_done_one_cycle", i), done_o, 0);
            check($sformatf("v%0d_idle_after", i), {busy_o, phase_o}, 0);
            check($sformatf("v%0d_irq", i), irq_o, vecs[i].exp_irq);
            clr_i = 1'b1;
            @(negedge ACLK);
            clr_i = 1'b0;
            check($sformatf("v%0d_irq_cleared", i), irq_o, 0);
        end

        // Abort during EZ_WAIT of step 2, coinciding with ez_done.
        num_steps_i = 3; smp_int_i = 0; int_en_i = 1'b1;
        start_i = 1'b1;
        @(negedge ACLK);
        start_i = 1'b0;
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            if (ez_start_o && step_cnt_o == 1) begin
                seen = 1;
                break;
            end
            @(negedge ACLK);
        end
        check("abort_reach_ez2", seen, 1);
        @(negedge ACLK);
        check("abort_in_ez_wait", phase_o, 2);
        abort_i = 1'b1;
        @(negedge ACLK);
        abort_i = 1'b0;
        check("abort_ack", aborted_o, 1);
        check("abort_idle", {busy_o, phase_o}, 0);
        check("abort_step_hold", step_cnt_o, 1);
        check("abort_no_done", done_o, 0);
        @(negedge ACLK);
        check("abort_ack_one_cycle", aborted_o, 0);
        check("abort_no_src", src_start_o, 0);
        check("abort_no_irq", irq_o, 0);
        check("abort_step_still", step_cnt_o, 1);
        repeat (2) @(negedge ACLK);
        num_steps_i = 1;
        run_seq(100, dc, hn, sn, sd, hf);
        check("fresh_done_cycle", dc, 7);
        check("fresh_step", sd, 1);
        check("fresh_hy_first", hf, 1);
        @(negedge ACLK);
        clr_i = 1'b1;
        @(negedge ACLK);
        clr_i = 1'b0;

        // Stray ez_done during HY_WAIT plus start while busy.
        auto_en = 1'b0; int_en_i = 1'b0;
        num_steps_i = 2;
        start_i = 1'b1;
        @(negedge ACLK);
        start_i = 1'b0;
        check("stray_hy_start", hy_start_o, 1);
        @(negedge ACLK);
        ez_done_m = 1'b1; start_i = 1'b1; num_steps_i = 7;
        @(negedge ACLK);
        ez_done_m = 1'b0; start_i = 1'b0;
        check("stray_still_hy", phase_o, 1);
        check("stray_no_ez_start", {hy_start_o, ez_start_o}, 0);
        hy_done_m = 1'b1;
        @(negedge ACLK);
        hy_done_m = 1'b0;
        check("stray_ez_after_hy", ez_start_o, 1);
        auto_en = 1'b1;
        extra_hy = 0; dc = -1;
        for (int k = 0; k < 60; k++) begin
            if (hy_start_o) extra_hy++;
            if (done_o) begin
                dc = k;
                break;
            end
            @(negedge ACLK);
        end
        check("stray_finished", dc >= 0, 1);
        check("stray_latched_num", step_cnt_o, 2);
        check("stray_hy_steps", extra_hy, 1);
        @(negedge ACLK);

        // irq set coinciding with clr: the set wins.
        num_steps_i = 0; int_en_i = 1'b1;
        start_i = 1'b1;
        @(negedge ACLK);
        start_i = 1'b0;
        check("irqclr_fin", done_o, 1);
        clr_i = 1'b1;
        @(negedge ACLK);
        clr_i = 1'b0;
        check("irqclr_set_wins", irq_o, 1);
        clr_i = 1'b1;
        @(negedge ACLK);
        clr_i = 1'b0;
        check("irqclr_cleared", irq_o, 0);

        // Reset in mid-run.
        num_steps_i = 3; int_en_i = 1'b1;
        start_i = 1'b1;
        @(negedge ACLK);
        start_i = 1'b0;
        repeat (8) @(negedge ACLK);
        ARESET = 1'b1;
        @(negedge ACLK);
        check("rst_mid_idle", {busy_o, phase_o}, 0);
        check("rst_mid_pulses", {hy_start_o, ez_start_o, src_start_o, smp_start_o, done_o}, 0);
        ARESET = 1'b0;
        repeat (3) @(negedge ACLK);
        check("rst_mid_no_done", {done_o, irq_o}, 0);

        // Withheld hy_done: watchdog trips after WDOG wait cycles when built in.
        auto_en = 1'b0; num_steps_i = 1;
        start_i = 1'b1;
        @(negedge ACLK);
        start_i = 1'b0;
        check("wd_hy_start", hy_start_o, 1);
        repeat (16) @(negedge ACLK);
        check("wd_before_limit", {err_o, phase_o}, 1);
        @(negedge ACLK);
`ifdef FDTD_SCHED_WDOG_EN
        check("wd_err_phase", phase_o, 7);
        check("wd_err_flag", err_o, 1);
        check("wd_not_busy", busy_o, 0);
        start_i = 1'b1;
        @(negedge ACLK);
        start_i = 1'b0;
        check("wd_start_ignored", phase_o, 7);
        clr_i = 1'b1;
        @(negedge ACLK);
        clr_i = 1'b0;
        check("wd_clr_idle", phase_o, 0);
        check("wd_clr_err", err_o, 0);
`else
        check("nowd_holds", phase_o, 1);
        check("nowd_no_err", err_o, 0);
        check("nowd_busy", busy_o, 1);
        abort_i = 1'b1;
        @(negedge ACLK);
        abort_i = 1'b0;
        check("nowd_abort_idle", phase_o, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
